// File: rtl/gt_link_pkg.sv
// Shared link definitions: 8b/10b control bytes, fixed link words and framer states.
// Latency: none (constants, types and pure functions only).
// Backpressure: n/a.
//
// Reused by the transmit framer and the future receive deframer/checker so that
// both ends agree on framing words and state names.
package gt_link_pkg;

    // 8b/10b control and data byte values used on the link
    localparam logic [7:0] K28_5 = 8'hBC;   // comma, idle filler
    localparam logic [7:0] K27_7 = 8'hFB;   // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;   // end of frame
    localparam logic [7:0] D16_2 = 8'h50;   // idle padding data byte
    localparam logic [7:0] SOF_PAD = 8'h5A; // SOF padding data byte

    // Complete 32-bit link words; the K character always sits in byte 0
    localparam logic [31:0] IDLE_WORD = {D16_2, D16_2, D16_2, K28_5};
    localparam logic [31:0] SOF_WORD  = {SOF_PAD, SOF_PAD, SOF_PAD, K27_7};
    localparam logic [31:0] EOF_WORD  = {24'h00_0000, K29_7};

    // charisk patterns: K in byte 0 only, or pure data
    localparam logic [3:0] K_LSB  = 4'b0001;
    localparam logic [3:0] K_NONE = 4'b0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SOF  = 3'd1,
        HDR  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        EOF  = 3'd5
    } fr_state_e;

    // One word on the GT user interface together with its K flags
    typedef struct packed {
        logic [3:0]  charisk;
        logic [31:0] data;
    } gt_word_t;

    function automatic gt_word_t mk_word(input logic [3:0] k, input logic [31:0] d);
        gt_word_t w;
        w.charisk = k;
        w.data    = d;
        return w;
    endfunction

    // Header word: sequence number in the upper half, payload length in the lower
    function automatic gt_word_t hdr_word(input logic [15:0] seq, input logic [15:0] len);
        return mk_word(K_NONE, {seq, len});
    endfunction

endpackage

// File: rtl/gt_tx_framer.sv
// Frames a 32-bit payload stream into SOF/HDR/payload/CSUM/EOF for a GT transmitter, idles between.
// Latency: one gt_clk; the word chosen in a state is registered onto txdata/txcharisk next cycle.
// Backpressure: s_tready only in DATA; none from the GT, so gaps in s_tvalid become in-frame idles.
//
// Ports:
//   gt_clk, gt_rst          GT user clock; asynchronous active-high reset
//   fr_enable               frames may start only while high (an open frame always completes)
//   fr_clear                one-cycle pulse, zeroes sequence number and frame counter
//   s_tdata/s_tvalid/s_tready  upstream payload stream (transfer on s_tvalid & s_tready)
//   txdata/txcharisk        registered word and K flags to the GT
//   fr_busy                 high whenever a frame is in progress
//   fr_count                frames completed (EOF sent), wraps at 16 bits
module gt_tx_framer
    import gt_link_pkg::*;
#(
    parameter int PAYLOAD_LEN = 16,  // 1..256
    parameter int MIN_GAP     = 2    // 1..15
) (
    input  logic        gt_clk,
    input  logic        gt_rst,
    input  logic        fr_enable,
    input  logic        fr_clear,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] txdata,
    output logic [3:0]  txcharisk,
    output logic        fr_busy,
    output logic [15:0] fr_count
);

    // Word counter is wide enough to hold 256
    localparam int               WCNT_W  = 9;
    localparam logic [WCNT_W-1:0] LEN_CNT = WCNT_W'(PAYLOAD_LEN);
    localparam logic [15:0]      LEN_HDR = 16'(PAYLOAD_LEN);
    localparam logic [3:0]       GAP_MIN = 4'(MIN_GAP);
    localparam logic [3:0]       GAP_SAT = 4'd15;

    fr_state_e          state_q, state_d;
    logic [3:0]         gap_q, gap_d;
    logic [15:0]        seq_q, seq_d;
    logic [15:0]        frcnt_q, frcnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [31:0]        csum_q, csum_d;
    gt_word_t           word_q, word_d;
    logic               take;

    assign s_tready  = (state_q == DATA);
    assign take      = s_tvalid & s_tready;
    assign fr_busy   = (state_q != IDLE);
    assign fr_count  = frcnt_q;
    assign txdata    = word_q.data;
    assign txcharisk = word_q.charisk;

    always_ff @(posedge gt_clk or posedge gt_rst) begin
        if (gt_rst) begin
            state_q <= IDLE;
            gap_q   <= GAP_MIN;     // gap starts satisfied so the first frame is not delayed
            seq_q   <= 16'd0;
            frcnt_q <= 16'd0;
            wcnt_q  <= '0;
            csum_q  <= 32'd0;
            word_q  <= mk_word(K_LSB, IDLE_WORD);
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            seq_q   <= seq_d;
            frcnt_q <= frcnt_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        seq_d   = seq_q;
        frcnt_d = frcnt_q;
        wcnt_d  = wcnt_q;
        csum_d  = csum_q;
        word_d  = mk_word(K_LSB, IDLE_WORD);

        case (state_q)
            IDLE: begin
                if (gap_q != GAP_SAT) begin
                    gap_d = gap_q + 4'd1;
                end
                // A frame only opens when a payload word is already waiting, so
                // DATA normally starts without pause fillers.
                if (fr_enable && s_tvalid && (gap_q >= GAP_MIN)) begin
                    state_d = SOF;
                end
            end
            SOF: begin
                word_d  = mk_word(K_LSB, SOF_WORD);
                csum_d  = 32'd0;
                state_d = HDR;
            end
            HDR: begin
                word_d  = hdr_word(seq_q, LEN_HDR);
                wcnt_d  = LEN_CNT;
                state_d = DATA;
            end
            DATA: begin
                // Without a transfer the idle default goes out as an in-frame
                // filler; the far end discards commas inside a frame.
                if (take) begin
                    word_d = mk_word(K_NONE, s_tdata);
                    csum_d = csum_q + s_tdata;
                    wcnt_d = wcnt_q - 1'b1;
                    if (wcnt_q == WCNT_W'(1)) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                word_d  = mk_word(K_NONE, csum_q);
                state_d = EOF;
            end
            EOF: begin
                word_d  = mk_word(K_LSB, EOF_WORD);
                seq_d   = seq_q + 16'd1;
                frcnt_d = frcnt_q + 16'd1;
                gap_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides the EOF increment; the frame itself is left untouched.
        if (fr_clear) begin
            seq_d   = 16'd0;
            frcnt_d = 16'd0;
        end
    end

endmodule

// File: tb/tb_gt_tx_framer.sv
// Testbench for gt_tx_framer: directed vector table, hand-timed corner sequences and random streams.
// Latency: n/a (simulation only).
// Backpressure: source holds each word until it is taken on s_tvalid & s_tready.
`timescale 1ns/1ps
module tb_gt_tx_framer;

    localparam int LEN = 4;
    localparam int GAP = 2;

    localparam logic [31:0] W_IDLE = 32'h5050_50BC;
    localparam logic [31:0] W_SOF  = 32'h5A5A_5AFB;
    localparam logic [31:0] W_EOF  = 32'h0000_00FD;
    localparam logic [35:0] IDLE36 = {4'b0001, W_IDLE};
    localparam logic [35:0] SOF36  = {4'b0001, W_SOF};
    localparam logic [35:0] EOF36  = {4'b0001, W_EOF};

    logic        gt_clk = 1'b0;
    logic        gt_rst;
    logic        fr_enable;
    logic        fr_clear;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] txdata;
    logic [3:0]  txcharisk;
    logic        fr_busy;
    logic [15:0] fr_count;

    gt_tx_framer #(.PAYLOAD_LEN(LEN), .MIN_GAP(GAP)) dut (
        .gt_clk    (gt_clk),
        .gt_rst    (gt_rst),
        .fr_enable (fr_enable),
        .fr_clear  (fr_clear),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .txdata    (txdata),
        .txcharisk (txcharisk),
        .fr_busy   (fr_busy),
        .fr_count  (fr_count)
    );

    always #5 gt_clk = ~gt_clk;

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] dat;
        logic [31:0] txd;
        logic [3:0]  k;
        logic        rdy;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t        tbl[15];
    int          errors = 0;
    int          checks = 0;
    logic [35:0] cap[$];
    logic [31:0] src_q[$];
    logic [31:0] words_q[$];
    int          acc;
    logic [15:0] m_seq;
    logic [15:0] m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic en, input logic vld, input logic [31:0] dat,
                                 input logic [31:0] txd, input logic [3:0] k,
                                 input logic rdy, input logic busy, input logic [15:0] cnt);
        vec_t v;
        v.en = en; v.vld = vld; v.dat = dat; v.txd = txd;
        v.k = k; v.rdy = rdy; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    // One clock: drive inputs after the edge, capture outputs on the falling edge.
    task automatic step(input logic en, input logic vld, input logic clr);
        @(posedge gt_clk); #1;
        fr_enable = en;
        fr_clear  = clr;
        s_tvalid  = vld && (src_q.size() > 0);
        s_tdata   = (src_q.size() > 0) ? src_q[0] : $urandom();
        @(negedge gt_clk);
        cap.push_back({txcharisk, txdata});
        if (s_tvalid && s_tready) begin
            void'(src_q.pop_front());
            acc++;
        end
    endtask

    // Reference: the non-idle word stream implied by words_q, plus the idle gap rule.
    task automatic check_frames(input string nm, input logic [15:0] seq0);
        logic [35:0] exp[$];
        logic [35:0] got[$];
        logic [31:0] sum;
        logic [15:0] s;
        int          nidle;
        bit          after_eof;
        s = seq0;
        for (int f = 0; f < words_q.size() / LEN; f++) begin
            sum = 32'd0;
            exp.push_back(SOF36);
            exp.push_back({4'b0000, s, 16'(LEN)});
            for (int i = 0; i < LEN; i++) begin
                exp.push_back({4'b0000, words_q[f*LEN+i]});
                sum += words_q[f*LEN+i];
            end
            exp.push_back({4'b0000, sum});
            exp.push_back(EOF36);
            s++;
        end
        after_eof = 0;
        nidle = 0;
        foreach (cap[i]) begin
            if (cap[i] == IDLE36) begin
                nidle++;
            end else begin
                if (cap[i] == SOF36 && after_eof)
                    chk($sformatf("%s gap>=MIN_GAP", nm), 64'(nidle >= GAP), 64'd1);
                if (cap[i] == EOF36) after_eof = 1;
                nidle = 0;
                got.push_back(cap[i]);
            end
        end
        chk($sformatf("%s word count", nm), 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s word%0d", nm, i), 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic run_words(input string nm, input int vld_pct, input int pause_at);
        int pause;
        int nfr;
        src_q = words_q;
        cap.delete();
        acc = 0;
        pause = 0;
        for (int c = 0; c < 3000 && src_q.size() > 0; c++) begin
            if (acc == pause_at && pause < 3) begin
                step(1'b1, 1'b0, 1'b0);
                pause++;
            end else begin
                step(1'b1, $urandom_range(0, 99) < vld_pct, 1'b0);
            end
        end
        chk($sformatf("%s drained", nm), 64'(src_q.size()), 64'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        check_frames(nm, m_seq);
        nfr = words_q.size() / LEN;
        m_seq += 16'(nfr);
        m_cnt += 16'(nfr);
        chk($sformatf("%s fr_count", nm), 64'(fr_count), 64'(m_cnt));
        chk($sformatf("%s busy idle", nm), 64'(fr_busy), 64'd0);
    endtask

    // Fixed-timing frame from an idle, gap-satisfied framer with continuous valid:
    // step 0 IDLE, 1 SOF, 2 HDR, 3..6 DATA, 7 CSUM, 8 EOF.
    task automatic run_timed(input int en_off, input int clr_at, input int nsteps);
        cap.delete();
        acc = 0;
        for (int s = 0; s < nsteps; s++)
            step(s < en_off, 1'b1, s == clr_at);
    endtask

    initial begin
        int n;
        gt_rst = 1'b1; fr_enable = 1'b0; fr_clear = 1'b0; s_tvalid = 1'b0; s_tdata = 32'd0;
        m_seq = 16'd0; m_cnt = 16'd0;
        repeat (3) @(posedge gt_clk);
        #1 gt_rst = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h1234_5678;

        // Disabled: only idle commas, never ready, no frames
        for (int c = 0; c < 6; c++) begin
            @(negedge gt_clk);
            chk($sformatf("dis%0d txdata", c), 64'(txdata), 64'(W_IDLE));
            chk($sformatf("dis%0d charisk", c), 64'(txcharisk), 64'h1);
            chk($sformatf("dis%0d tready", c), 64'(s_tready), 64'd0);
            chk($sformatf("dis%0d busy", c), 64'(fr_busy), 64'd0);
            chk($sformatf("dis%0d fr_count", c), 64'(fr_count), 64'd0);
        end

        // Directed frame 1,2,3,4 and the start of the next frame
        tbl[0]  = mkv(1, 1, 32'hDEAD_BEEF, W_IDLE,       4'b0001, 0, 0, 16'd0);
        tbl[1]  = mkv(1, 1, 32'hDEAD_BEEF, W_IDLE,       4'b0001, 0, 1, 16'd0);
        tbl[2]  = mkv(1, 1, 32'hDEAD_BEEF, W_SOF,        4'b0001, 0, 1, 16'd0);
        tbl[3]  = mkv(1, 1, 32'd1,         32'h0000_0004, 4'b0000, 1, 1, 16'd0);
        tbl[4]  = mkv(1, 1, 32'd2,         32'd1,         4'b0000, 1, 1, 16'd0);
        tbl[5]  = mkv(1, 1, 32'd3,         32'd2,         4'b0000, 1, 1, 16'd0);
        tbl[6]  = mkv(1, 1, 32'd4,         32'd3,         4'b0000, 1, 1, 16'd0);
        tbl[7]  = mkv(1, 1, 32'hDEAD_BEEF, 32'd4,         4'b0000, 0, 1, 16'd0);
        tbl[8]  = mkv(1, 1, 32'hDEAD_BEEF, 32'h0000_000A, 4'b0000, 0, 1, 16'd0);
        tbl[9]  = mkv(1, 1, 32'hDEAD_BEEF, W_EOF,        4'b0001, 0, 0, 16'd1);
        tbl[10] = mkv(1, 1, 32'hDEAD_BEEF, W_IDLE,       4'b0001, 0, 0, 16'd1);
        tbl[11] = mkv(1, 1, 32'hDEAD_BEEF, W_IDLE,       4'b0001, 0, 0, 16'd1);
        tbl[12] = mkv(1, 1, 32'hDEAD_BEEF, W_IDLE,       4'b0001, 0, 1, 16'd1);
        tbl[13] = mkv(1, 1, 32'hDEAD_BEEF, W_SOF,        4'b0001, 0, 1, 16'd1);
        tbl[14] = mkv(1, 1, 32'd5,         32'h0001_0004, 4'b0000, 1, 1, 16'd1);
        for (int i = 0; i < 15; i++) begin
            @(posedge gt_clk); #1;
            fr_enable = tbl[i].en;
            s_tvalid  = tbl[i].vld;
            s_tdata   = tbl[i].dat;
            @(negedge gt_clk);
            chk($sformatf("vec%0d txdata", i), 64'(txdata), 64'(tbl[i].txd));
            chk($sformatf("vec%0d charisk", i), 64'(txcharisk), 64'(tbl[i].k));
            chk($sformatf("vec%0d tready", i), 64'(s_tready), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d busy", i), 64'(fr_busy), 64'(tbl[i].busy));
            chk($sformatf("vec%0d fr_count", i), 64'(fr_count), 64'(tbl[i].cnt));
        end

        // Reset in the middle of DATA: immediate and held return to the reset state
        #2 gt_rst = 1'b1;
        #1;
        chk("rst txdata", 64'(txdata), 64'(W_IDLE));
        chk("rst charisk", 64'(txcharisk), 64'h1);
        chk("rst tready", 64'(s_tready), 64'd0);
        chk("rst busy", 64'(fr_busy), 64'd0);
        chk("rst fr_count", 64'(fr_count), 64'd0);
        @(posedge gt_clk);
        @(negedge gt_clk);
        chk("rst held txdata", 64'(txdata), 64'(W_IDLE));
        chk("rst held tready", 64'(s_tready), 64'd0);
        gt_rst = 1'b0;
        m_seq = 16'd0;
        m_cnt = 16'd0;

        words_q.delete();
        for (int i = 0; i < LEN; i++) words_q.push_back($urandom());
        run_words("post_rst", 100, -1);

        // Three-cycle valid gap after the second payload word
        words_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_words("pause", 100, 2);
        n = -1;
        foreach (cap[i]) if (n < 0 && cap[i] == {4'b0000, 32'd2}) n = i;
        if (n >= 0) begin
            int k;
            k = 0;
            while (n + 1 + k < cap.size() && cap[n+1+k] == IDLE36) k++;
            chk("pause fillers", 64'(k), 64'd3);
        end else begin
            chk("pause word2 seen", 64'd0, 64'd1);
        end

        // Checksum wraps modulo 2^32
        words_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_words("wrap", 100, -1);
        n = -1;
        foreach (cap[i]) if (n < 0 && cap[i] == EOF36) n = i;
        if (n > 0) chk("wrap csum", 64'(cap[n-1]), 64'({4'b0000, 32'hFFFF_FFFC}));
        else       chk("wrap eof seen", 64'd0, 64'd1);

        // Enable dropped in HDR: frame finishes, later words stay upstream
        words_q.delete();
        for (int i = 0; i < LEN; i++) words_q.push_back($urandom());
        src_q = words_q;
        for (int i = 0; i < 4; i++) src_q.push_back($urandom());
        run_timed(2, -1, 30);
        check_frames("en_drop", m_seq);
        m_seq++; m_cnt++;
        chk("en_drop left upstream", 64'(src_q.size()), 64'd4);
        chk("en_drop busy", 64'(fr_busy), 64'd0);
        chk("en_drop fr_count", 64'(fr_count), 64'(m_cnt));
        src_q.delete();

        // Clear during DATA: frame intact, counters restart then count this EOF
        words_q.delete();
        for (int i = 0; i < LEN; i++) words_q.push_back($urandom());
        src_q = words_q;
        run_timed(1000, 4, 20);
        check_frames("clr_data", m_seq);
        m_seq = 16'd1; m_cnt = 16'd1;
        chk("clr_data fr_count", 64'(fr_count), 64'(m_cnt));

        // Clear coincident with EOF: clear wins
        words_q.delete();
        for (int i = 0; i < LEN; i++) words_q.push_back($urandom());
        src_q = words_q;
        run_timed(1000, 8, 20);
        check_frames("clr_eof", m_seq);
        m_seq = 16'd0; m_cnt = 16'd0;
        chk("clr_eof fr_count", 64'(fr_count), 64'(m_cnt));

        // Random payload with random valid gaps
        words_q.delete();
        for (int i = 0; i < 5 * LEN; i++) words_q.push_back($urandom());
        run_words("random", 70, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
